serial_adder: RTL
=================

# serial_adder

Bit-serial ripple adder that adds two W-bit operands one bit per clock using a single full-adder cell and a registered carry. It sits directly downstream of the team's one-bit full-adder cells and consumes their sum/carry outputs each cycle, trading W cycles of latency for one adder's worth of logic. Operands are loaded in parallel on a start pulse, and the result is presented in parallel with a one-cycle done pulse.

## Interface
- W, 8, operand and sum width in bits (W ≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  W  operand A, captured on the accepted start edge
- b  input  W  operand B, captured on the accepted start edge
- ci  input  1  carry-in, captured on the accepted start edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse in DONE; result valid
- s  output  W  sum; holds last result until the next completion
- co  output  1  carry-out; holds last result until the next completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1 at an edge: capture a→shift_a, b→shift_b, ci→carry, clear the bit counter, and go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - The full-adder cell sees shift_a[0], shift_b[0] and carry.
  - Its sum enters shift_s at the MSB while shift_s shifts right.
  - carry ← cell carry-out; shift_a and shift_b shift right; counter increments.
- RUN, edge where counter = W-1: the last bit is processed, and the fully assembled value is written to s and co on that same edge (s ← {cell sum, shift_s[W-1:1]}, co ← cell carry-out). Go to DONE.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- start outside IDLE (RUN or DONE) is ignored: no restart, no effect on operands or result.
- Result arithmetic: {co, s} = a + b + ci, evaluated modulo 2^(W+1). There is no signed interpretation and no overflow flag.
- Counter width is clog2(W). The counter never wraps within one operation.

## Timing
- Reset (asynchronous assert, any state):
  - state=IDLE; busy=0; done=0; s=0; co=0.
  - All shift registers, carry and counter are cleared.
- Reset asserted mid-RUN aborts the operation: no done pulse and no partial result on s.
- Deassertion is synchronous to clk. The first accepted start is on the first rising edge with rst_n=1.
- Latency: start accepted at edge k → busy high in cycles after edges k..k+W-1 → s/co updated at edge k+W → done high for the cycle after edge k+W → IDLE after edge k+W+1.
- Throughput: one operation per W+2 cycles. A start held high continuously is accepted again at edge k+W+2.
- s and co change only at the completion edge. They are stable through DONE and IDLE.
- busy and done are never high together. done is never high for two consecutive cycles.

## Structure
- Shared package serial_adder_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default width constant W_DEF = 8.
- One sub-module: the existing one-bit full adder fa_case (ports s, co, a, b, ci), instantiated once and combinationally fed from shift_a[0], shift_b[0] and carry.
- All other logic is local: FSM, counter, three W-bit shift registers, carry flop and output registers.

## Test plan
- Reset, then start with a=8'h00, b=8'h00, ci=0 → done at start edge+W+1 (W=8), s=8'h00, co=0; busy high for exactly 8 cycles.
- Start with a=8'hFF, b=8'h01, ci=0 → s=8'h00, co=1. Then a=8'h7F, b=8'h01, ci=1 → s=8'h81, co=0.
- Start with a=8'hFF, b=8'hFF, ci=1 → s=8'hFF, co=1. s and co hold through 5 idle cycles after done.
- Pulse start with a=8'h12, b=8'h34 in cycles 3 and 8 of a running 8'h01+8'h02 → only s=8'h03 is produced; one done pulse.
- Assert rst_n=0 at cycle 4 of a run → busy, done, s and co go to 0 immediately. After release, 8'h0A+8'h05 ci=0 → s=8'h0F.
- Hold start=1 continuously with random operands, 200 operations, W=8 and W=3 → each {co,s} equals a+b+ci; done spacing is exactly W+2 cycles.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/fa_case.sv
// One-bit full adder cell, written as a truth table.
module fa_case (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  always_comb begin
    s  = 1'b0;
    co = 1'b0;
    case ({a, b, ci})
      3'b001, 3'b010, 3'b100: s = 1'b1;
      3'b011, 3'b101, 3'b110: co = 1'b1;
      3'b111: begin s = 1'b1; co = 1'b1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one fa_case cell, registered carry, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         co
);
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  logic [W-1:0]   shift_a, shift_b;
  // The final sum bit goes straight to s, so only W-1 accumulated bits are ever read.
  logic [W-1:1]   shift_s;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           fs, fco;

  fa_case u_fa (.s(fs), .co(fco), .a(shift_a[0]), .b(shift_b[0]), .ci(carry));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift_a <= '0;
      shift_b <= '0;
      shift_s <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s       <= '0;
      co      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          shift_a <= a;
          shift_b <= b;
          carry   <= ci;
          cnt     <= '0;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          shift_a <= {1'b0, shift_a[W-1:1]};
          shift_b <= {1'b0, shift_b[W-1:1]};
          shift_s <= (W > 2) ? {fs, shift_s[W-1:2]} : fs;
          carry   <= fco;
          if (cnt == LAST) begin
            s     <= {fs, shift_s};
            co    <= fco;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
